// File: rtl/compare_detect_dr.sv
// -----------------------------------------------------------------------------
// compare_detect_dr
//
// Purpose:
//   Dual-rail compare/detect stage on a single clock.
//   - Waits in IDLE for a complete dual-rail codeword.
//   - Evaluates one comparison of the codeword against CMP_VAL.
//   - Presents the one-bit outcome as a dual-rail token on ctrl.
//   - Completes a four-phase handshake with the downstream ctrl_ack.
//   - Returns to IDLE once the input has gone back to spacer.
//
// Parameters:
//   W        number of dual-rail input bits (default pa_AsyncCordic::EW+1)
//   CMP_VAL  W-bit unsigned comparison constant
//
// Ports:
//   clk       single clock; all state changes on its rising edge
//   arst      synchronous, active-high reset
//   data_i    W dual-rail operand bits (spacer 00, valid 01/10, illegal 11)
//   mode      comparison select, sampled only when a codeword is accepted:
//             00 ==CMP_VAL, 01 !=CMP_VAL, 10 all ones, 11 >CMP_VAL (unsigned)
//   ack_i     input acknowledge (high in DRIVE and RELEASE)
//   ctrl      dual-rail result: data_1 = true, data_0 = false, 00 = spacer
//   ctrl_ack  downstream acknowledge
//   err       sticky illegal-code flag (only with the macro below)
//
// Configuration:
//   `define COMPARE_DETECT_ERR_DETECT_EN adds the err port and the ERROR state.
//   - Any 11 bit seen in IDLE latches err and parks the block in ERROR.
//   - Only reset leaves ERROR.
//   Without the macro, an 11 bit decodes as logic 1 for both completeness and
//   value.
// -----------------------------------------------------------------------------

package pa_AsyncCordic;
    localparam int EW = 7;

    typedef struct packed {
        logic data_1;
        logic data_0;
    } dual_rail_t;
endpackage

module compare_detect_dr #(
    parameter int              W       = pa_AsyncCordic::EW + 1,
    parameter logic [W-1:0]    CMP_VAL = {W{1'b0}}
) (
    input  logic                              clk,
    input  logic                              arst,
    input  pa_AsyncCordic::dual_rail_t [W-1:0] data_i,
    input  logic [1:0]                        mode,
    output logic                              ack_i,
    output pa_AsyncCordic::dual_rail_t        ctrl,
    input  logic                              ctrl_ack
`ifdef COMPARE_DETECT_ERR_DETECT_EN
    ,
    output logic                              err
`endif
);

    import pa_AsyncCordic::*;

`ifdef COMPARE_DETECT_ERR_DETECT_EN
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        RELEASE = 2'b10,
        ERROR   = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        RELEASE = 2'b10
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Dual-rail decode helpers
    // ------------------------------------------------------------------

    // Binary value of the codeword. data_1 is the bit value, so 10 -> 1 and
    // 01 -> 0. An illegal 11 also reads as 1.
    function automatic logic [W-1:0] dr_value(input dual_rail_t [W-1:0] d);
        logic [W-1:0] v;
        v = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            v[i] = d[i].data_1;
        end
        return v;
    endfunction

    // Every bit has left spacer. An 11 bit counts as present.
    function automatic logic dr_complete(input dual_rail_t [W-1:0] d);
        logic c;
        c = 1'b1;
        for (int i = 0; i < W; i++) begin
            c = c & (d[i].data_1 | d[i].data_0);
        end
        return c;
    endfunction

    // Every bit is back at 00.
    function automatic logic dr_spacer(input dual_rail_t [W-1:0] d);
        logic s;
        s = 1'b1;
        for (int i = 0; i < W; i++) begin
            s = s & ~(d[i].data_1 | d[i].data_0);
        end
        return s;
    endfunction

`ifdef COMPARE_DETECT_ERR_DETECT_EN
    // At least one bit carries the illegal 11 code.
    function automatic logic dr_any_illegal(input dual_rail_t [W-1:0] d);
        logic a;
        a = 1'b0;
        for (int i = 0; i < W; i++) begin
            a = a | (d[i].data_1 & d[i].data_0);
        end
        return a;
    endfunction
`endif

    // Comparison selected by mode.
    function automatic logic cmp_eval(input logic [W-1:0] v, input logic [1:0] m);
        logic r;
        case (m)
            2'b00:   r = (v == CMP_VAL);
            2'b01:   r = (v != CMP_VAL);
            2'b10:   r = &v;
            2'b11:   r = (v > CMP_VAL);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [W-1:0] value_s;
    logic         complete_s;
    logic         spacer_s;
    logic         eval_s;

    state_t       state_r;
    state_t       state_nxt_s;
    logic         result_r;
    logic         result_nxt_s;
    dual_rail_t   ctrl_r;
    dual_rail_t   ctrl_nxt_s;
    logic         ack_r;
    logic         ack_nxt_s;

`ifdef COMPARE_DETECT_ERR_DETECT_EN
    logic         illegal_s;
    logic         err_r;
    logic         err_nxt_s;
`endif

    // Decode the incoming codeword.
    always_comb begin
        value_s    = dr_value(data_i);
        complete_s = dr_complete(data_i);
        spacer_s   = dr_spacer(data_i);
        eval_s     = cmp_eval(value_s, mode);
    end

`ifdef COMPARE_DETECT_ERR_DETECT_EN
    // Flag any illegal bit on the input.
    always_comb begin
        illegal_s = dr_any_illegal(data_i);
    end
`endif

    // Next-state logic. The result is captured only on acceptance and held
    // until the next one, so changes on data_i/mode in DRIVE cannot disturb it.
    always_comb begin
        state_nxt_s  = state_r;
        result_nxt_s = result_r;
`ifdef COMPARE_DETECT_ERR_DETECT_EN
        err_nxt_s    = err_r;
`endif
        case (state_r)
            IDLE: begin
`ifdef COMPARE_DETECT_ERR_DETECT_EN
                if (illegal_s) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = 1'b1;
                end else
`endif
                if (complete_s && !ctrl_ack) begin
                    state_nxt_s  = DRIVE;
                    result_nxt_s = eval_s;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            DRIVE: begin
                if (ctrl_ack) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = DRIVE;
                end
            end
            RELEASE: begin
                // Spacer and ctrl_ack low in the same cycle is one transition.
                if (spacer_s && !ctrl_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
`ifdef COMPARE_DETECT_ERR_DETECT_EN
            ERROR: begin
                state_nxt_s = ERROR;
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the state being entered. Registering these at the
    // same edge as the state gives one-edge latency with glitch-free outputs.
    // Only DRIVE raises a ctrl rail, and then exactly one.
    always_comb begin
        ctrl_nxt_s = 2'b00;
        ack_nxt_s  = 1'b0;
        case (state_nxt_s)
            DRIVE: begin
                ctrl_nxt_s.data_1 = result_nxt_s;
                ctrl_nxt_s.data_0 = ~result_nxt_s;
                ack_nxt_s         = 1'b1;
            end
            RELEASE: begin
                ctrl_nxt_s = 2'b00;
                ack_nxt_s  = 1'b1;
            end
            default: begin
                ctrl_nxt_s = 2'b00;
                ack_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, held result and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r  <= IDLE;
            result_r <= 1'b0;
            ctrl_r   <= 2'b00;
            ack_r    <= 1'b0;
`ifdef COMPARE_DETECT_ERR_DETECT_EN
            err_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            result_r <= result_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            ack_r    <= ack_nxt_s;
`ifdef COMPARE_DETECT_ERR_DETECT_EN
            err_r    <= err_nxt_s;
`endif
        end
    end

    assign ctrl  = ctrl_r;
    assign ack_i = ack_r;
`ifdef COMPARE_DETECT_ERR_DETECT_EN
    assign err   = err_r;
`endif

endmodule

// File: doc/compare_detect_dr.md
COMPARE_DETECT_DR -- requirements
Module: compare_detect_dr

Interface
REQ-001 SHALL have parameter W, default pa_AsyncCordic::EW+1, the number of dual-rail input bits.
REQ-002 SHALL have parameter CMP_VAL, default 0, a W-bit unsigned comparison constant.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port data_i, input, pa_AsyncCordic::dual_rail_t[W-1:0], the dual-rail operand.
REQ-006 SHALL have port mode, input, 2, comparison select, sampled only at codeword acceptance.
REQ-007 SHALL have port ack_i, output, 1, the input acknowledge.
REQ-008 SHALL have port ctrl, output, pa_AsyncCordic::dual_rail_t, the dual-rail result: data_1 = true, data_0 = false.
REQ-009 SHALL have port ctrl_ack, input, 1, the downstream acknowledge.
REQ-010 SHALL have port err, output, 1, sticky illegal-code flag; present only under ERR_DETECT_EN.

Function
REQ-011 SHALL classify each bit as follows: spacer = 00, valid = 01 or 10, illegal = 11.
REQ-012 SHALL define the codeword as complete when all W bits are valid, and as spacer when all W bits are 00.
REQ-013 SHALL evaluate the result by mode: 00 value==CMP_VAL; 01 value!=CMP_VAL; 10 value is all ones; 11 value>CMP_VAL (unsigned).
REQ-014 SHALL implement FSM states IDLE, DRIVE, RELEASE, and ERROR (ERROR only under ERR_DETECT_EN).
REQ-015 IDLE SHALL: drive ctrl=00 and ack_i=0; on complete codeword with ctrl_ack=0, register the result and mode, then next cycle move to DRIVE.
REQ-016 IDLE SHALL ignore partial codewords: no state change and no output change.
REQ-017 IDLE SHALL hold off while ctrl_ack=1, even when the codeword is complete.
REQ-018 DRIVE SHALL: drive ctrl from the registered result (exactly one rail high) and ack_i=1; on ctrl_ack=1, move to RELEASE.
REQ-019 RELEASE SHALL: drive ctrl=00 and ack_i=1; when the input is spacer AND ctrl_ack=0, move to IDLE.
REQ-020 Latency SHALL be: complete codeword sampled at edge n gives ctrl valid and ack_i=1 from edge n+1; ctrl_ack=1 at edge m gives ctrl=00 from edge m+1.
REQ-021 SHALL keep the result stable in DRIVE even if data_i or mode change.
REQ-022 SHALL treat simultaneous spacer and ctrl_ack fall as a single transition to IDLE; no cycle may be skipped or duplicated.
REQ-023 SHALL never drive both ctrl rails high in any state.

Reset
REQ-024 arst=1 at a rising edge SHALL force: state IDLE, ctrl=00, ack_i=0, registered result=0, err=0.
REQ-025 Reset asserted mid-handshake (DRIVE or RELEASE) SHALL abandon the transaction; after release the block restarts in IDLE and requires a fresh complete codeword.
REQ-026 SHALL keep outputs at reset values for every cycle arst is high.

Configuration
REQ-027 Macro COMPARE_DETECT_ERR_DETECT_EN defined SHALL: on any illegal bit seen in IDLE, set err=1 and enter ERROR (ctrl=00, ack_i=0), leaving ERROR only via reset.
REQ-028 Macro undefined SHALL: omit port err and state ERROR, and decode an illegal bit as logic 1 for completeness and comparison.

Verification (W=8, CMP_VAL=0)
REQ-029 SHALL cover: mode=00, data=0x00 complete, ctrl_ack=0 -> ctrl=10 and ack_i=1 at next edge; ctrl_ack=1 -> ctrl=00; spacer with ctrl_ack=0 -> ack_i=0, IDLE.
REQ-030 SHALL cover: mode=11, data=0x05 -> ctrl=10; mode=10, data=0xFE -> ctrl=01; mode=01, data=0x00 -> ctrl=01.
REQ-031 SHALL cover: 7 of 8 bits valid for 10 cycles -> ctrl=00 and ack_i=0 throughout; 8th bit valid -> ctrl valid one edge later.
REQ-032 SHALL cover: complete codeword while ctrl_ack=1 -> no acceptance; ctrl_ack falls -> accepted next edge.
REQ-033 SHALL cover: arst=1 pulse during DRIVE -> ctrl=00, ack_i=0 next edge; bench replays a full transaction correctly.
REQ-034 SHALL cover, with the macro defined: bit3=11 in IDLE -> err=1, ctrl=00, ack_i=0 held until arst.
